// File: rtl/mem_pkg.sv
// Shared definitions for the memory controller: FSM encoding, IO port address
// default, access direction constants and the RAM range decode helper.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [31:0] IO_ADDR_DEFAULT = 32'hFFFF_0000;
  localparam logic        RW_READ         = 1'b0;
  localparam logic        RW_WRITE        = 1'b1;

  // True when the full 32-bit word address falls inside a 2^depth_log2-word RAM.
  function automatic logic addr_in_ram(input logic [31:0] addr, input int depth_log2);
    return (addr >> depth_log2) == 32'd0;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Core-to-controller bus: request side driven by the core (master), completion,
// status and IO port driven by the controller (slave).
interface mem_ctrl_if;
  logic        req;
  logic [31:0] address;
  logic        rw;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;
  logic [7:0]  io_out;
  logic        io_strobe;

  modport master (
    output req, address, rw, wdata,
    input  rdata, ready, busy, err, io_out, io_strobe
  );

  modport slave (
    input  req, address, rw, wdata,
    output rdata, ready, busy, err, io_out, io_strobe
  );
endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM, one 32-bit word per address, registered read.
// Contents are deliberately not reset.
module mem_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem_r [0:(1<<DEPTH_LOG2)-1];

  // Storage write and registered read port
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
    rdata <= mem_r[addr];
  end

endmodule

// File: rtl/mem_ctrl.sv
// Word-addressed memory controller: latches one request, inserts WAIT_STATES
// cycles, then serves it from RAM, the IO byte port, or flags an address error.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  mem_ctrl_if.slave  bus
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [31:0] addr_r;
  logic        rw_r;
  logic [31:0] wdata_r;
  logic [31:0] rdata_r;
  logic        ready_r;
  logic        busy_r;
  logic        err_r;
  logic [7:0]  io_out_r;
  logic        io_strobe_r;
  logic        ram_rd_r;
  logic        in_ram_s;
  logic        is_io_s;
  logic        ram_we_s;
  logic [31:0] ram_q_s;

  assign in_ram_s = addr_in_ram(addr_r, DEPTH_LOG2);
  assign is_io_s  = (addr_r == IO_ADDR);
  assign ram_we_s = (state_r == ST_ACCESS) && in_ram_s && (rw_r == RW_WRITE);

  mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem_array (
    .clock (clock),
    .we    (ram_we_s),
    .addr  (addr_r[DEPTH_LOG2-1:0]),
    .wdata (wdata_r),
    .rdata (ram_q_s)
  );

  // Request FSM with wait counter, request latches, decode side effects and status
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      addr_r      <= 32'd0;
      rw_r        <= RW_READ;
      wdata_r     <= 32'd0;
      rdata_r     <= 32'd0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
      io_out_r    <= 8'd0;
      io_strobe_r <= 1'b0;
      ram_rd_r    <= 1'b0;
    end else begin
      ready_r     <= 1'b0;
      io_strobe_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.req) begin
            addr_r  <= bus.address;
            rw_r    <= bus.rw;
            wdata_r <= bus.wdata;
            busy_r  <= 1'b1;
            if (WAIT_STATES > 0) begin
              state_r <= ST_WAIT;
              cnt_r   <= WAIT_LOAD;
            end else begin
              state_r <= ST_ACCESS;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r <= ST_ACCESS;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_ACCESS: begin
          state_r  <= ST_DONE;
          ready_r  <= 1'b1;
          // RAM read data only lands in the DONE cycle, so it is forwarded there
          ram_rd_r <= in_ram_s && (rw_r == RW_READ);
          if (!in_ram_s) begin
            if (is_io_s) begin
              if (rw_r == RW_WRITE) begin
                io_out_r    <= wdata_r[7:0];
                io_strobe_r <= 1'b1;
              end else begin
                rdata_r <= {24'd0, io_out_r};
              end
            end else begin
              err_r <= 1'b1;
              if (rw_r == RW_READ) begin
                rdata_r <= 32'd0;
              end
            end
          end
        end
        ST_DONE: begin
          state_r  <= ST_IDLE;
          busy_r   <= 1'b0;
          ram_rd_r <= 1'b0;
          if (ram_rd_r) begin
            rdata_r <= ram_q_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rdata     = ram_rd_r ? ram_q_s : rdata_r;
  assign bus.ready     = ready_r;
  assign bus.busy      = busy_r;
  assign bus.err       = err_r;
  assign bus.io_out    = io_out_r;
  assign bus.io_strobe = io_strobe_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed scoreboard bench for mem_ctrl: one instance with two wait states and
// one with none, sharing the core-side stimulus with a per-instance request gate.
module tb_mem_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        sel_s;
  logic        req_s;
  logic        rw_s;
  logic [31:0] address_s;
  logic [31:0] wdata_s;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] sb_q [$];
  logic [31:0] last_rd;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  mem_ctrl_if bus_a ();
  mem_ctrl_if bus_z ();

  assign bus_a.req     = req_s & sel_s;
  assign bus_a.address = address_s;
  assign bus_a.rw      = rw_s;
  assign bus_a.wdata   = wdata_s;
  assign bus_z.req     = req_s & ~sel_s;
  assign bus_z.address = address_s;
  assign bus_z.rw      = rw_s;
  assign bus_z.wdata   = wdata_s;

  mem_ctrl #(.DEPTH_LOG2(10), .WAIT_STATES(2)) dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  mem_ctrl #(.DEPTH_LOG2(10), .WAIT_STATES(0)) dut_z (.clock(clock), .reset(reset), .bus(bus_z));

  logic [31:0] o_rdata;
  logic        o_ready, o_busy, o_err, o_strobe;
  logic [7:0]  o_io;

  always_comb begin
    if (sel_s) begin
      o_rdata = bus_a.rdata; o_ready = bus_a.ready; o_busy = bus_a.busy;
      o_err = bus_a.err; o_strobe = bus_a.io_strobe; o_io = bus_a.io_out;
    end else begin
      o_rdata = bus_z.rdata; o_ready = bus_z.ready; o_busy = bus_z.busy;
      o_err = bus_z.err; o_strobe = bus_z.io_strobe; o_io = bus_z.io_out;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdata"}, o_rdata, 32'd0);
    chk({tag, "_ready"}, 32'(o_ready), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_err"}, 32'(o_err), 32'd0);
    chk({tag, "_io_out"}, 32'(o_io), 32'd0);
    chk({tag, "_io_strobe"}, 32'(o_strobe), 32'd0);
  endtask

  // One complete access; poke raises req once while the controller is busy.
  task automatic access(input logic is_wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input int lat, input logic exp_strobe,
                        input logic exp_err, input logic poke, output int t_ready);
    int k;
    logic [31:0] exp_v;
    @(negedge clock);
    chk("idle_before_req", 32'(o_busy), 32'd0);
    req_s = 1'b1; rw_s = is_wr; address_s = a; wdata_s = d;
    if (!is_wr) sb_q.push_back(exp_rd);
    @(negedge clock);
    req_s = 1'b0;
    chk("busy_after_sample", 32'(o_busy), 32'd1);
    if (poke) begin
      req_s = 1'b1; rw_s = 1'b0; address_s = 32'd1024;
    end
    k = 1;
    while (o_ready !== 1'b1 && k < 40) begin
      @(negedge clock);
      req_s = 1'b0;
      k++;
    end
    t_ready = cyc;
    chk("ready_seen", 32'(o_ready), 32'd1);
    chk("latency", 32'(k), 32'(lat));
    chk("io_strobe", 32'(o_strobe), 32'(exp_strobe));
    chk("err", 32'(o_err), 32'(exp_err));
    if (!is_wr) begin
      exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hBAD0_BAD0;
      chk("rdata", o_rdata, exp_v);
      last_rd = exp_v;
    end else begin
      chk("rdata_hold", o_rdata, last_rd);
    end
  endtask

  initial begin
    int t [4];
    int td;
    reset = 1'b1; sel_s = 1'b0; req_s = 1'b0; rw_s = 1'b0;
    address_s = 32'd0; wdata_s = 32'd0; last_rd = 32'd0;
    repeat (2) @(negedge clock);
    chk_all_zero("reset_z");
    sel_s = 1'b1;
    #1 chk_all_zero("reset_a");
    sel_s = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // zero wait states: preload 0..3 then back-to-back reads
    for (int i = 0; i < 4; i++)
      access(1'b1, 32'(i), 32'(i + 1), 32'd0, 2, 1'b0, 1'b0, 1'b0, td);
    for (int i = 0; i < 4; i++)
      access(1'b0, 32'(i), 32'd0, 32'(i + 1), 2, 1'b0, 1'b0, 1'b0, t[i]);
    for (int i = 1; i < 4; i++)
      chk("b2b_period", 32'(t[i] - t[i-1]), 32'd3);

    // two wait states
    sel_s = 1'b1; last_rd = 32'd0;
    access(1'b1, 32'd5, 32'hDEAD_BEEF, 32'd0, 4, 1'b0, 1'b0, 1'b0, td);
    access(1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, 4, 1'b0, 1'b0, 1'b0, td);
    access(1'b1, 32'd1023, 32'hA5A5_5A5A, 32'd0, 4, 1'b0, 1'b0, 1'b0, td);
    access(1'b0, 32'd1023, 32'd0, 32'hA5A5_5A5A, 4, 1'b0, 1'b0, 1'b1, td);
    @(negedge clock); chk("poke_ignored_1", 32'(o_busy), 32'd0);
    @(negedge clock); chk("poke_ignored_2", 32'(o_busy), 32'd0);
    chk("poke_no_err", 32'(o_err), 32'd0);

    access(1'b1, 32'hFFFF_0000, 32'h0000_0141, 32'd0, 4, 1'b1, 1'b0, 1'b0, td);
    chk("io_out", 32'(o_io), 32'h41);
    access(1'b0, 32'hFFFF_0000, 32'd0, 32'h0000_0041, 4, 1'b0, 1'b0, 1'b0, td);
    access(1'b1, 32'hFFFF_0001, 32'h0000_0077, 32'd0, 4, 1'b0, 1'b1, 1'b0, td);
    chk("io_no_alias", 32'(o_io), 32'h41);

    access(1'b0, 32'd1024, 32'd0, 32'd0, 4, 1'b0, 1'b1, 1'b0, td);
    access(1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, 4, 1'b0, 1'b1, 1'b0, td);
    access(1'b1, 32'd7, 32'h0000_1234, 32'd0, 4, 1'b0, 1'b1, 1'b0, td);

    // reset lands mid-WAIT of an overwrite of address 7
    @(negedge clock);
    req_s = 1'b1; rw_s = 1'b1; address_s = 32'd7; wdata_s = 32'hFFFF_FFFF;
    @(negedge clock);
    req_s = 1'b0;
    chk("busy_in_wait", 32'(o_busy), 32'd1);
    #2 reset = 1'b1;
    #1 chk_all_zero("async_reset");
    @(negedge clock);
    reset = 1'b0; last_rd = 32'd0;
    access(1'b0, 32'd7, 32'd0, 32'h0000_1234, 4, 1'b0, 1'b0, 1'b0, td);
    access(1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, 4, 1'b0, 1'b0, 1'b0, td);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
